// File: rtl/ctrl_pkg.sv
// Shared constants for the control pipeline: default sizes, writeback-select codes
// and the hard-wired zero register index.
package ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_RW    = 5;

  localparam int REG_ZERO  = 0;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/ctrl_pipe_n_if.sv
// Bundle between decode/hazard logic (master) and the control pipeline (slave).
interface ctrl_pipe_n_if #(
  parameter int WIDTH = ctrl_pkg::DEF_WIDTH,
  parameter int DEPTH = ctrl_pkg::DEF_DEPTH,
  parameter int RW    = ctrl_pkg::DEF_RW
) ();
  import ctrl_pkg::*;

  logic                  in_valid;
  logic                  in_we;
  logic [RW-1:0]         in_rd;
  logic [WIDTH-1:0]      in_ctrl;
  logic [DEPTH-1:0]      stall;
  logic [DEPTH-1:0]      flush;
  logic [RW-1:0]         rs1;
  logic [RW-1:0]         rs2;

  logic [DEPTH-1:0]      stage_valid;
  logic [DEPTH-1:0]      stage_we;
  logic [DEPTH*RW-1:0]   stage_rd;
  logic                  out_valid;
  logic                  out_we;
  logic [RW-1:0]         out_rd;
  logic [WIDTH-1:0]      out_ctrl;
  logic [DEPTH-1:0]      hit1;
  logic [DEPTH-1:0]      hit2;

  modport master (
    output in_valid, in_we, in_rd, in_ctrl, stall, flush, rs1, rs2,
    input  stage_valid, stage_we, stage_rd, out_valid, out_we, out_rd, out_ctrl, hit1, hit2
  );

  modport slave (
    input  in_valid, in_we, in_rd, in_ctrl, stall, flush, rs1, rs2,
    output stage_valid, stage_we, stage_rd, out_valid, out_we, out_rd, out_ctrl, hit1, hit2
  );

endinterface

// File: rtl/ctrl_pipe_slot.sv
// One control-pipeline stage: applies reset, flush, hold, bubble and load in that
// priority order.
module ctrl_pipe_slot
  import ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RW    = DEF_RW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             prev_hold_i,
  input  logic             flush_i,
  input  logic             src_valid_i,
  input  logic             src_we_i,
  input  logic [RW-1:0]    src_rd_i,
  input  logic [WIDTH-1:0] src_ctrl_i,
  output logic             valid_o,
  output logic             we_o,
  output logic [RW-1:0]    rd_o,
  output logic [WIDTH-1:0] ctrl_o
);

  logic             valid_q, valid_d;
  logic             we_q, we_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      // a flushed slot still tracks its payload unless the stage is frozen
      valid_d = 1'b0;
      we_d    = 1'b0;
      if (!hold_i) begin
        rd_d   = src_rd_i;
        ctrl_d = src_ctrl_i;
      end
    end else if (hold_i) begin
      valid_d = valid_q;
    end else if (prev_hold_i) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      rd_d    = '0;
      ctrl_d  = '0;
    end else begin
      valid_d = src_valid_i;
      we_d    = src_we_i;
      rd_d    = src_rd_i;
      ctrl_d  = src_ctrl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign we_o    = we_q;
  assign rd_o    = rd_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/ctrl_pipe_n.sv
// DEPTH-stage control pipeline with stall/flush, gated write-enables and
// per-stage RAW-hazard match outputs.
module ctrl_pipe_n
  import ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int RW    = DEF_RW
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_pipe_n_if.slave     bus
);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] we_s;
  logic [RW-1:0]    rd_s   [DEPTH];
  logic [WIDTH-1:0] ctrl_s [DEPTH];

  // a stall anywhere downstream freezes every earlier stage
  always_comb begin
    hold = '0;
    hold[DEPTH-1] = bus.stall[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      hold[i] = bus.stall[i] | hold[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic             src_valid;
    logic             src_we;
    logic [RW-1:0]    src_rd;
    logic [WIDTH-1:0] src_ctrl;
    logic             prev_hold;

    if (i == 0) begin : g_head
      assign src_valid = bus.in_valid;
      assign src_we    = bus.in_we & bus.in_valid;
      assign src_rd    = bus.in_rd;
      assign src_ctrl  = bus.in_ctrl;
      assign prev_hold = 1'b0;
    end else begin : g_body
      assign src_valid = valid_s[i-1];
      assign src_we    = we_s[i-1];
      assign src_rd    = rd_s[i-1];
      assign src_ctrl  = ctrl_s[i-1];
      assign prev_hold = hold[i-1];
    end

    ctrl_pipe_slot #(.WIDTH(WIDTH), .RW(RW)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .hold_i      (hold[i]),
      .prev_hold_i (prev_hold),
      .flush_i     (bus.flush[i]),
      .src_valid_i (src_valid),
      .src_we_i    (src_we),
      .src_rd_i    (src_rd),
      .src_ctrl_i  (src_ctrl),
      .valid_o     (valid_s[i]),
      .we_o        (we_s[i]),
      .rd_o        (rd_s[i]),
      .ctrl_o      (ctrl_s[i])
    );
  end

  logic [DEPTH-1:0]    gated_we;
  logic [DEPTH*RW-1:0] rd_flat;
  logic [DEPTH-1:0]    hit1_c;
  logic [DEPTH-1:0]    hit2_c;

  always_comb begin
    gated_we = valid_s & we_s;
    rd_flat  = '0;
    hit1_c   = '0;
    hit2_c   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_flat[i*RW +: RW] = rd_s[i];
      hit1_c[i] = gated_we[i] && (rd_s[i] == bus.rs1) && (bus.rs1 != RW'(REG_ZERO));
      hit2_c[i] = gated_we[i] && (rd_s[i] == bus.rs2) && (bus.rs2 != RW'(REG_ZERO));
    end
  end

  assign bus.stage_valid = valid_s;
  assign bus.stage_we    = gated_we;
  assign bus.stage_rd    = rd_flat;
  assign bus.out_valid   = valid_s[DEPTH-1];
  assign bus.out_we      = gated_we[DEPTH-1];
  assign bus.out_rd      = rd_s[DEPTH-1];
  assign bus.out_ctrl    = ctrl_s[DEPTH-1];
  assign bus.hit1        = hit1_c;
  assign bus.hit2        = hit2_c;

endmodule

// File: tb/tb_ctrl_pipe_n.sv
// Bench for ctrl_pipe_n (DEPTH=2): directed vector table, then random traffic
// against a stage-array reference model.
module tb_ctrl_pipe_n;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int RW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_n_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RW(RW)) bus ();

  ctrl_pipe_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       iv;
    logic       iw;
    logic [4:0] ird;
    logic [3:0] ictrl;
    logic [1:0] st;
    logic [1:0] fl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] ev;
    logic [1:0] ewe;
    logic [9:0] erd;
    logic [3:0] ectrl;
    logic [1:0] eh1;
    logic [1:0] eh2;
  } vec_t;

  typedef struct {
    logic       v;
    logic       we;
    logic [4:0] rd;
    logic [3:0] ctrl;
  } ent_t;

  ent_t model [DEPTH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ev, input logic [1:0] ewe,
                           input logic [9:0] erd, input logic [3:0] ectrl,
                           input logic [1:0] eh1, input logic [1:0] eh2);
    chk({tag, " stage_valid"}, 32'(bus.stage_valid), 32'(ev));
    chk({tag, " stage_we"},    32'(bus.stage_we),    32'(ewe));
    chk({tag, " stage_rd"},    32'(bus.stage_rd),    32'(erd));
    chk({tag, " out_valid"},   32'(bus.out_valid),   32'(ev[1]));
    chk({tag, " out_we"},      32'(bus.out_we),      32'(ewe[1]));
    chk({tag, " out_rd"},      32'(bus.out_rd),      32'(erd[9:5]));
    chk({tag, " out_ctrl"},    32'(bus.out_ctrl),    32'(ectrl));
    chk({tag, " hit1"},        32'(bus.hit1),        32'(eh1));
    chk({tag, " hit2"},        32'(bus.hit2),        32'(eh2));
  endtask

  task automatic drive(input logic r, input logic iv, input logic iw, input logic [4:0] ird,
                       input logic [3:0] ictrl, input logic [1:0] st, input logic [1:0] fl,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    rst          = r;
    bus.in_valid = iv;
    bus.in_we    = iw;
    bus.in_rd    = ird;
    bus.in_ctrl  = ictrl;
    bus.stall    = st;
    bus.flush    = fl;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
  endtask

  // Reference: each stage decides from the rules what it holds after the edge.
  task automatic model_step();
    ent_t nxt [DEPTH];
    ent_t src;
    logic frozen, upstream_frozen;
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        nxt[i] = '{1'b0, 1'b0, 5'd0, 4'd0};
        continue;
      end
      frozen = 1'b0;
      for (int j = i; j < DEPTH; j++) if (bus.stall[j]) frozen = 1'b1;
      upstream_frozen = 1'b0;
      if (i > 0) for (int j = i - 1; j < DEPTH; j++) if (bus.stall[j]) upstream_frozen = 1'b1;
      if (i == 0) src = '{bus.in_valid, bus.in_we & bus.in_valid, bus.in_rd, bus.in_ctrl};
      else        src = model[i-1];
      nxt[i] = model[i];
      if (bus.flush[i]) begin
        nxt[i].v  = 1'b0;
        nxt[i].we = 1'b0;
        if (!frozen) begin
          nxt[i].rd   = src.rd;
          nxt[i].ctrl = src.ctrl;
        end
      end else if (frozen) begin
        nxt[i] = model[i];
      end else if (upstream_frozen) begin
        nxt[i] = '{1'b0, 1'b0, 5'd0, 4'd0};
      end else begin
        nxt[i] = src;
      end
    end
    for (int i = 0; i < DEPTH; i++) model[i] = nxt[i];
  endtask

  task automatic model_check(input int cyc);
    logic [1:0] ev, ewe, eh1, eh2;
    logic [9:0] erd;
    for (int i = 0; i < DEPTH; i++) begin
      ev[i]  = model[i].v;
      ewe[i] = model[i].v && model[i].we;
      erd[i*5 +: 5] = model[i].rd;
      eh1[i] = ewe[i] && model[i].rd == bus.rs1 && bus.rs1 != 0;
      eh2[i] = ewe[i] && model[i].rd == bus.rs2 && bus.rs2 != 0;
    end
    check_all($sformatf("rnd%0d", cyc), ev, ewe, erd, model[DEPTH-1].ctrl, eh1, eh2);
  endtask

  vec_t tbl [19];

  initial begin
    //          rst iv iw ird    ctrl   st     fl     rs1    rs2    ev     ewe    erd              ctrl   h1     h2
    tbl[0]  = '{1, 0, 0, 5'd0,  4'h0, 2'b00, 2'b00, 5'd0,  5'd0,  2'b00, 2'b00, {5'd0,  5'd0},  4'h0, 2'b00, 2'b00};
    tbl[1]  = '{1, 1, 1, 5'd3,  4'h2, 2'b00, 2'b00, 5'd3,  5'd0,  2'b00, 2'b00, {5'd0,  5'd0},  4'h0, 2'b00, 2'b00};
    tbl[2]  = '{0, 1, 1, 5'd5,  4'hA, 2'b00, 2'b00, 5'd5,  5'd0,  2'b01, 2'b01, {5'd0,  5'd5},  4'h0, 2'b01, 2'b00};
    tbl[3]  = '{0, 0, 0, 5'd0,  4'h0, 2'b00, 2'b00, 5'd0,  5'd5,  2'b10, 2'b10, {5'd5,  5'd0},  4'hA, 2'b00, 2'b10};
    tbl[4]  = '{0, 1, 1, 5'd5,  4'h3, 2'b00, 2'b00, 5'd0,  5'd0,  2'b01, 2'b01, {5'd0,  5'd5},  4'h0, 2'b00, 2'b00};
    tbl[5]  = '{0, 1, 1, 5'd9,  4'h7, 2'b01, 2'b00, 5'd0,  5'd0,  2'b01, 2'b01, {5'd0,  5'd5},  4'h0, 2'b00, 2'b00};
    tbl[6]  = '{0, 1, 1, 5'd9,  4'h7, 2'b01, 2'b00, 5'd0,  5'd0,  2'b01, 2'b01, {5'd0,  5'd5},  4'h0, 2'b00, 2'b00};
    tbl[7]  = '{0, 1, 0, 5'd9,  4'h7, 2'b00, 2'b00, 5'd9,  5'd5,  2'b11, 2'b10, {5'd5,  5'd9},  4'h3, 2'b00, 2'b10};
    tbl[8]  = '{0, 1, 1, 5'd7,  4'h2, 2'b00, 2'b10, 5'd7,  5'd9,  2'b01, 2'b01, {5'd9,  5'd7},  4'h7, 2'b01, 2'b00};
    tbl[9]  = '{0, 1, 1, 5'd0,  4'h1, 2'b00, 2'b00, 5'd7,  5'd0,  2'b11, 2'b11, {5'd7,  5'd0},  4'h2, 2'b10, 2'b00};
    tbl[10] = '{0, 1, 1, 5'd7,  4'h5, 2'b00, 2'b00, 5'd7,  5'd0,  2'b11, 2'b11, {5'd0,  5'd7},  4'h1, 2'b01, 2'b00};
    tbl[11] = '{0, 1, 1, 5'd3,  4'h6, 2'b01, 2'b01, 5'd7,  5'd0,  2'b00, 2'b00, {5'd0,  5'd7},  4'h0, 2'b00, 2'b00};
    tbl[12] = '{0, 0, 0, 5'd0,  4'h0, 2'b00, 2'b00, 5'd7,  5'd0,  2'b00, 2'b00, {5'd7,  5'd0},  4'h5, 2'b00, 2'b00};
    tbl[13] = '{0, 1, 1, 5'd4,  4'h8, 2'b00, 2'b00, 5'd0,  5'd0,  2'b01, 2'b01, {5'd0,  5'd4},  4'h0, 2'b00, 2'b00};
    tbl[14] = '{0, 1, 1, 5'd6,  4'h9, 2'b00, 2'b00, 5'd4,  5'd6,  2'b11, 2'b11, {5'd4,  5'd6},  4'h8, 2'b10, 2'b01};
    tbl[15] = '{0, 1, 1, 5'd2,  4'hF, 2'b10, 2'b00, 5'd4,  5'd6,  2'b11, 2'b11, {5'd4,  5'd6},  4'h8, 2'b10, 2'b01};
    tbl[16] = '{1, 1, 1, 5'd2,  4'hF, 2'b00, 2'b00, 5'd4,  5'd6,  2'b00, 2'b00, {5'd0,  5'd0},  4'h0, 2'b00, 2'b00};
    tbl[17] = '{0, 1, 1, 5'd11, 4'hC, 2'b00, 2'b00, 5'd11, 5'd11, 2'b01, 2'b01, {5'd0,  5'd11}, 4'h0, 2'b01, 2'b01};
    tbl[18] = '{0, 0, 1, 5'd12, 4'hD, 2'b00, 2'b00, 5'd12, 5'd11, 2'b10, 2'b10, {5'd11, 5'd12}, 4'hC, 2'b00, 2'b10};

    drive(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 2'b00, 2'b00, 5'd0, 5'd0);

    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      drive(tbl[k].rst, tbl[k].iv, tbl[k].iw, tbl[k].ird, tbl[k].ictrl,
            tbl[k].st, tbl[k].fl, tbl[k].rs1, tbl[k].rs2);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ewe, tbl[k].erd,
                tbl[k].ectrl, tbl[k].eh1, tbl[k].eh2);
    end

    // Random traffic, starting from a reset cycle so the model is aligned.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      drive((c == 0) || ($urandom_range(31) == 0),
            1'($urandom_range(3) != 0), 1'($urandom),
            5'($urandom_range(7)), 4'($urandom),
            {1'($urandom_range(4) == 0), 1'($urandom_range(4) == 0)},
            {1'($urandom_range(7) == 0), 1'($urandom_range(7) == 0)},
            5'($urandom_range(7)), 5'($urandom_range(7)));
      @(posedge clk);
      model_step();
      #1;
      model_check(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_n.md
# ctrl_pipe_n

Parametrised control-signal pipeline that carries a decoded control bundle (write-enable, destination register, writeback select and other control bits) from decode through DEPTH register stages toward writeback. It generalises the fixed two-field X→M control register with four additions: a per-stage valid bit, per-stage stall and flush with bubble insertion, write-enable gating on invalid slots, and per-stage RAW-hazard match outputs for the forwarding and interlock logic. One instance serves the whole CPU control path. Stage 0 is the X-side register and stage DEPTH-1 feeds writeback.

## Interface
- WIDTH, default 4: width of the opaque control bundle (e.g. wb_sel, mem flags).
- DEPTH, default 2: number of pipeline stages, ≥1.
- RW, default 5: register-index width.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a real instruction is presented to stage 0.
- in_we  in  1  register write-enable of the incoming instruction.
- in_rd  in  RW  destination register of the incoming instruction.
- in_ctrl  in  WIDTH  opaque control bundle.
- stall  in  DEPTH  stall[i] requests that stage i hold.
- flush  in  DEPTH  flush[i] kills the instruction in stage i.
- rs1, rs2  in  RW  source registers of the instruction in decode.
- stage_valid  out  DEPTH  valid bit of each stage.
- stage_we  out  DEPTH  gated write-enable per stage (we & valid).
- stage_rd  out  DEPTH*RW  rd per stage; stage i occupies bits [i*RW +: RW].
- out_valid, out_we, out_rd, out_ctrl  out  1/1/RW/WIDTH  stage DEPTH-1 contents. out_we is gated.
- hit1, hit2  out  DEPTH  bit i is set when stage i matches rs1 or rs2, respectively.

## Operation
- Effective hold: hold[i] = OR of stall[j] for j ≥ i. A stalled later stage freezes every earlier stage.
- Per stage i, the first matching rule applies at each edge:
  - rst: valid = 0, we = 0, rd = 0, ctrl = 0.
  - flush[i]: valid = 0 and we = 0. rd and ctrl keep their current values if hold[i] is set; otherwise they load from the source.
  - hold[i]: all fields keep their current values.
  - i > 0 and hold[i-1]: bubble. valid = 0, we = 0, rd = 0, ctrl = 0.
  - otherwise: load from the source. The source is stage i-1 for i > 0, and the in_* inputs for stage 0.
- Stage 0 load takes in_valid and in_we & in_valid.
- Gating: stage_we[i] = we[i] & valid[i]. A flushed or bubbled slot never drives a register write.
- Hazard match: hit1[i] = valid[i] & we[i] & (rd[i] == rs1) & (rs1 != 0). hit2 uses rs2 the same way. These are combinational from the stage registers; a match against x0 is never reported.
- All outputs are combinational views of the stage registers. There is no output logic beyond the we gating and the comparators.

## Timing
- Latency: an unstalled instruction accepted at edge t appears at stage k after edge t+k. It appears on out_* after edge t+DEPTH-1.
- Reset: every output is 0 from the first edge with rst=1 until the first edge after rst falls. rst mid-flight discards all in-flight entries, and no write-enable survives it.
- Stall: a held stage keeps its value for every cycle stall is high. The stage directly after the stall point receives one bubble per stalled cycle.
- Flush and stall on the same stage in the same cycle: the slot becomes invalid and the payload is held. It remains invalid until refilled.
- Flush of stage i does not affect stages j ≠ i. The caller asserts a flush mask covering every stage to be squashed.
- hit1 and hit2 reflect the registers after the most recent edge. There is no same-cycle bypass of in_*.

## Structure
- Shared package ctrl_pkg holds the localparams for the default WIDTH, DEPTH and RW, the wb_sel encodings, and the constant REG_ZERO = 0.
- Natural sub-module: ctrl_pipe_slot, one stage. It has inputs hold, prev_hold, flush and the source fields, and it owns the priority rules and the reset. ctrl_pipe_n generates DEPTH slots, computes hold[] and implements the hazard comparators.

## Test plan
- Passthrough, DEPTH=2: in_valid=1, in_we=1, in_rd=5, in_ctrl=4'hA at edge 0. Required: out_valid=1, out_rd=5, out_ctrl=A, out_we=1 after edge 1.
- Stall: stall=2'b01 for 2 cycles with an instruction in stage 0. Required: stage 0 holds rd=5 for both cycles, stage 1 shows valid=0 and we=0 for 2 cycles, then rd=5 arrives.
- Flush: flush=2'b10 with a valid we=1 in stage 1. Required: out_valid=0 and out_we=0 next cycle; stage 0 advances normally.
- Stall and flush on the same stage: stall[0]=1 and flush[0]=1. Required: stage 0 valid=0 and rd unchanged; stage 1 gets a bubble.
- Hazard: stage 0 holds rd=7, we=1; stage 1 holds rd=0, we=1; rs1=7, rs2=0. Required: hit1=2'b01, hit2=2'b00. With stage 0 invalid, hit1=0.
- Reset mid-flight: rst=1 for one edge with both stages valid. Required: every output 0, and the next accepted instruction is the only valid entry.
